// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage, opcode-selected WIDTH-bit bitwise logic unit.
// S1 captures the operand beat, S2 is the output register holding the result
// and its flags. Valid/ready on both sides, capacity of two beats.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic             err,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_free;
    logic             accept;
    logic             s1_xfer;
    logic             consume;

    logic [WIDTH-1:0] res_y;
    logic             res_err;

    // S2 can take a new beat when empty or being drained this cycle; S1 likewise
    // can take one when empty or when it is handing its beat to S2.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign s1_xfer  = s1_valid && s2_free;
    assign consume  = out_valid && out_ready;

    // Result select from the S1 contents; illegal opcode forces y to zero.
    always_comb begin
        res_y   = '0;
        res_err = 1'b0;
        case (s1_op)
            OP_AND:  res_y = s1_a & s1_b;
            OP_OR:   res_y = s1_a | s1_b;
            OP_NOT:  res_y = ~s1_a;
            OP_NAND: res_y = ~(s1_a & s1_b);
            OP_NOR:  res_y = ~(s1_a | s1_b);
            OP_XOR:  res_y = s1_a ^ s1_b;
            OP_XNOR: res_y = ~(s1_a ^ s1_b);
            default: begin
                res_y   = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // S1 occupancy: a new accept wins over the transfer that empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_xfer) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 operand capture, only on accept so idle-cycle inputs have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= '0;
        end else if (accept) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
        end
    end

    // S2 output register: load on transfer, otherwise drop valid when consumed;
    // data and flags hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
            err       <= 1'b0;
        end else if (s1_xfer) begin
            out_valid <= 1'b1;
            y         <= res_y;
            zero      <= (res_y == '0);
            parity    <= ^res_y;
            err       <= res_err;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (consume) begin
            res_count <= res_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised-streaming bench for logic_unit_pipe.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        zero;
    logic        parity;
    logic        err;
    logic [15:0] res_count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [2:0]  w_op;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [7:0]  w_y;
    logic        w_zero;
    logic        w_parity;
    logic        w_err;
    logic [3:0]  w_res_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic mon_en = 1'b0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .err(err),
        .res_count(res_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .op(w_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .y(w_y), .zero(w_zero), .parity(w_parity), .err(w_err),
        .res_count(w_res_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] ref_beat(input logic [7:0] ra, input logic [7:0] rb,
                                             input logic [2:0] rop);
        logic [7:0] r;
        logic       e;
        e = 1'b0;
        case (rop)
            3'd0: r = ra & rb;
            3'd1: r = ra | rb;
            3'd2: r = ~ra;
            3'd3: r = ~(ra & rb);
            3'd4: r = ~(ra | rb);
            3'd5: r = ra ^ rb;
            3'd6: r = ~(ra ^ rb);
            default: begin r = 8'h00; e = 1'b1; end
        endcase
        return {r, (r == 8'h00), ^r, e};
    endfunction

    // Scoreboard: every delivered beat during streaming must match the queue head.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("stream_extra", 32'd1, 32'd0);
            else check("stream_res", {21'd0, y, zero, parity, err}, {21'd0, exp_q.pop_front()});
        end
    end

    logic [7:0] sweep_y [7] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};

    initial begin
        int sent;
        int cyc;
        logic [15:0] base;
        logic [15:0] delta;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = 8'h12; w_b = 8'h34; w_op = 3'd5; w_out_ready = 1'b1;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_flags", {zero, parity, err}, 0);
        check("rst_count", res_count, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Opcode sweep with 2-cycle latency checks
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op = 3'(i);
            tick();
            in_valid = 1'b0;
            check("sweep_lat", out_valid, 0);
            tick();
            check("sweep_valid", out_valid, 1);
            check("sweep_y", y, sweep_y[i]);
            check("sweep_flags", {zero, parity, err}, 3'b000);
        end

        // Odd parity and zero result
        in_valid = 1'b1; a = 8'h01; b = 8'h00; op = 3'd1;
        tick(); in_valid = 1'b0; tick();
        check("par_y", y, 8'h01);
        check("par_flags", {zero, parity, err}, 3'b010);
        in_valid = 1'b1; a = 8'h00; b = 8'h00; op = 3'd0;
        tick(); in_valid = 1'b0; tick();
        check("zero_flags", {zero, parity, err}, 3'b100);

        // Illegal opcode
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd7;
        tick(); in_valid = 1'b0; tick();
        check("ill_y", y, 8'h00);
        check("ill_flags", {zero, parity, err}, 3'b101);
        check("ill_cnt_before", res_count, 9);
        tick();
        check("ill_cnt_after", res_count, 10);

        // Back-pressure: three beats against a stalled consumer
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'hAA; b = 8'h0F; op = 3'd0;
        tick();
        check("bp_ready1", in_ready, 1);
        op = 3'd1;
        tick();
        check("bp_ready2", in_ready, 0);
        check("bp_y1", y, 8'h0A);
        op = 3'd5;
        tick();
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_y", y, 8'h0A);
        tick();
        check("bp_hold_y2", y, 8'h0A);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_y2", y, 8'hAF);
        tick();
        check("bp_y3", y, 8'hA5);
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_count", res_count, 13);

        // Random streaming against the reference model
        base = res_count;
        mon_en = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_beat(a, b, op));
                sent++;
            end
            tick();
            cyc++;
        end
        check("stream_sent", sent, 100);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 50) begin
            tick();
            cyc++;
        end
        mon_en = 1'b0;
        check("stream_left", exp_q.size(), 0);
        delta = res_count - base;
        check("stream_count", delta, 100);

        // Counter wrap on the CNT_W=4 instance
        w_in_valid = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        w_in_valid = 1'b0;
        tick(); tick(); tick();
        check("wrap_count", w_res_count, 1);
        check("wrap_idle", w_out_valid, 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h0F; b = 8'hF0; op = 3'd1;
        tick(); tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_y", y, 0);
        check("mid_rst_count", res_count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_wcount", w_res_count, 0);
        @(posedge clk); #1; rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 3'd5;
        tick();
        in_valid = 1'b0;
        check("post_rst_lat", out_valid, 0);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_y", y, 8'hFF);
        check("post_rst_flags", {zero, parity, err}, 3'b000);
        tick();
        check("post_rst_count", res_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: two WIDTH-bit operands plus a 3-bit opcode go in, and one registered result comes out, together with status flags. Both sides use valid/ready handshakes. It replaces the single-bit combinational gate set with a WIDTH-bit, opcode-selected, two-stage datapath that supports back-pressure. Beyond the gates, it adds illegal-opcode detection, zero and parity flags, and a wrapping result counter. It sits between an operand source and any streaming consumer in the datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of delivered-result counter (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept operand beat
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT)
- op  input  3  opcode
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result beat
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y
- err  output  1  beat carried illegal opcode
- res_count  output  CNT_W  number of result beats delivered (out_valid & out_ready), wraps

## Operation
- Opcodes:
  - 000 AND a&b
  - 001 OR a|b
  - 010 NOT ~a
  - 011 NAND ~(a&b)
  - 100 NOR ~(a|b)
  - 101 XOR a^b
  - 110 XNOR ~(a^b)
  - 111 illegal: y=0, err=1, zero=1, parity=0
- Stage 1 (S1): on in_valid & in_ready, register a, b, op; set s1_valid.
- Stage 2 (S2 = output register): when S1 holds a beat and the S2 slot is free, compute the result and flags from the S1 contents and register y, zero, parity, err; set out_valid.
- Slot-free rules, purely combinational:
  - s2_free = !out_valid | out_ready
  - in_ready = !s1_valid | s2_free
- S1 → S2 transfer: s1_valid & s2_free. S1 clears unless a new beat is accepted in the same cycle.
- S2 clears on out_valid & out_ready unless S1 transfers in the same cycle.
- Stall: while out_valid & !out_ready, y/zero/parity/err/out_valid hold stable. S1 holds its beat, and in_ready falls once S1 is occupied.
- res_count increments by 1 on each out_valid & out_ready. It wraps from 2^CNT_W−1 to 0. Illegal-op beats are counted.
- Inputs are sampled only on accept. Values on a/b/op outside accept cycles have no effect.
- No beat is dropped or duplicated. Order is preserved.

## Timing
- Latency: beat accepted at edge N → out_valid at edge N+1 (visible in cycle after N+1), i.e. 2 cycles from accept to consume when out_ready=1.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats (S1 + S2). With out_ready=0, the third beat sees in_ready=0.
- Simultaneous accept at input, S1→S2 transfer and output consume in one cycle: all three take effect, with no bubble.
- Reset values (rst high, asynchronous, no clock required):
  - s1_valid=0, out_valid=0, y=0, zero=0, parity=0, err=0, res_count=0
  - in_ready=1 while rst is high and after release
- Reset mid-operation discards all in-flight beats. The first beat after release returns to 2-cycle latency.

## Test plan
- WIDTH=8, out_ready=1: a=8'hF0, b=8'h3C, sweep op 000..110 → y = 30, FC, 0F, CF, 03, CC, 33 in order, each 2 cycles after accept; parity matches XOR-reduce; zero=0.
- op=111, a=8'hFF, b=8'hFF → y=00, err=1, zero=1, parity=0; res_count increments.
- Back-pressure: out_ready=0, present 3 beats back-to-back → first two accepted, in_ready=0 on third, y held stable; raise out_ready → results emerge in order, third accepted, none lost.
- Streaming: 100 random beats with random out_ready (50%) → every result matches reference model in order; res_count=100.
- Counter wrap, CNT_W=4: deliver 17 beats → res_count=1.
- Assert rst while 2 beats in flight → out_valid=0, y=0, res_count=0 immediately without a clock edge; post-release beat a=8'hAA, b=8'h55, op=101 → y=8'hFF after 2 cycles, zero=0, parity=0.
